// File: rtl/dist_mem_pkg.sv
// Shared widths and types for the distributed data RAM.
// Optional second read port is enabled with DIST_MEM_DPO_EN.
package dist_mem_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 512;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/dist_mem_valid_bits.sv
// Per-word valid flags: async clear, set on write, one or two read taps.
// The second tap exists only when DIST_MEM_DPO_EN is defined.
module dist_mem_valid_bits
    import dist_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic [ADDR_W-1:0] rd_addr,
`ifdef DIST_MEM_DPO_EN
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              rd2_valid,
`endif
    output logic              rd_valid
);

    logic [DEPTH-1:0] valid;

    // Clearing on reset is what makes unwritten words read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (set_en) begin
            valid[set_addr] <= 1'b1;
        end
    end

    assign rd_valid = valid[rd_addr];

`ifdef DIST_MEM_DPO_EN
    assign rd2_valid = valid[rd2_addr];
`endif

endmodule

// File: rtl/dist_mem_data.sv
// 512x32 data RAM: synchronous write, combinational read gated by valid bits.
// Define DIST_MEM_DPO_EN to add the read-only port dpra/dpo.
module dist_mem_data
    import dist_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] d,
    input  logic              we,
`ifdef DIST_MEM_DPO_EN
    input  logic [ADDR_W-1:0] dpra,
    output logic [DATA_W-1:0] dpo,
`endif
    output logic [DATA_W-1:0] spo
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [1:0]        rst_sync;
    logic              a_ok;
    logic              a_valid;
    logic              write_ok;

    // Reset asserts at once but releases only after two clean clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    // Addresses past DEPTH only exist when the array is not a full power of two.
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full
            assign a_ok = 1'b1;
        end else begin : g_partial
            assign a_ok = (32'(a) < DEPTH);
        end
    endgenerate

    assign write_ok = we && rst_sync[1] && a_ok;

    always_ff @(posedge clk) begin
        if (write_ok) begin
            mem[a] <= d;
        end
    end

`ifdef DIST_MEM_DPO_EN
    logic dpra_ok;
    logic dpra_valid;

    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full2
            assign dpra_ok = 1'b1;
        end else begin : g_partial2
            assign dpra_ok = (32'(dpra) < DEPTH);
        end
    endgenerate
`endif

    dist_mem_valid_bits #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_valid (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (write_ok),
        .set_addr  (a),
        .rd_addr   (a),
`ifdef DIST_MEM_DPO_EN
        .rd2_addr  (dpra),
        .rd2_valid (dpra_valid),
`endif
        .rd_valid  (a_valid)
    );

    assign spo = (a_ok && a_valid) ? mem[a] : '0;

`ifdef DIST_MEM_DPO_EN
    assign dpo = (dpra_ok && dpra_valid) ? mem[dpra] : '0;
`endif

endmodule

// File: tb/tb_dist_mem_data.sv
// Directed plus randomized bench for dist_mem_data against an array model.
// Covers the dpra/dpo port when DIST_MEM_DPO_EN is defined.
module tb_dist_mem_data;
    import dist_mem_pkg::*;

    logic  clk;
    logic  rst_n;
    addr_t a;
    word_t d;
    logic  we;
    word_t spo;
`ifdef DIST_MEM_DPO_EN
    addr_t dpra;
    word_t dpo;
`endif

    word_t exp_mem   [DEPTH_DEF];
    bit    exp_valid [DEPTH_DEF];
    int    vectors;
    int    miscompares;

    dist_mem_data dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .d     (d),
        .we    (we),
`ifdef DIST_MEM_DPO_EN
        .dpra  (dpra),
        .dpo   (dpo),
`endif
        .spo   (spo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic word_t model_read(input addr_t addr);
        return exp_valid[addr] ? exp_mem[addr] : '0;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH_DEF; i++) exp_valid[i] = 1'b0;
    endfunction

    task automatic compare(input string tag, input word_t observed, input word_t expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One write on the next rising edge; the model updates with it.
    task automatic apply_stimulus(input addr_t addr, input word_t data);
        @(negedge clk);
        a  = addr;
        d  = data;
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        exp_mem[addr]   = data;
        exp_valid[addr] = 1'b1;
    endtask

    task automatic check_output(input string tag, input addr_t addr);
        @(negedge clk);
        a = addr;
        #1;
        compare(tag, spo, model_read(addr));
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        we    = 1'b0;
        a     = '0;
        d     = '0;
`ifdef DIST_MEM_DPO_EN
        dpra  = '0;
`endif
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        compare("spo_in_reset", spo, 32'h0);
        release_reset();

        check_output("reset_0x000", 9'h000);
        check_output("reset_0x0ff", 9'h0FF);
        check_output("reset_0x1ff", 9'h1FF);
        compare("reset_0x1ff_const", spo, 32'h0000_0000);

        apply_stimulus(9'h005, 32'hDEAD_BEEF);
        check_output("wr_0x005", 9'h005);
        compare("wr_0x005_const", spo, 32'hDEAD_BEEF);
        check_output("neighbour_0x006", 9'h006);

        // Read during write: old value before the edge, new value after it.
        apply_stimulus(9'h010, 32'h1111_1111);
        @(negedge clk);
        a  = 9'h010;
        d  = 32'h2222_2222;
        we = 1'b1;
        #1;
        compare("rdw_before", spo, 32'h1111_1111);
        @(posedge clk);
        #1;
        we = 1'b0;
        exp_mem[9'h010] = 32'h2222_2222;
        compare("rdw_after", spo, 32'h2222_2222);

        apply_stimulus(9'h1FF, 32'hCAFE_F00D);
        apply_stimulus(9'h000, 32'h1234_5678);
        check_output("wr_0x1ff", 9'h1FF);
        check_output("wr_0x000", 9'h000);
        check_output("unwritten_0x100", 9'h100);

        apply_stimulus(9'h07A, 32'h0000_0001);
        apply_stimulus(9'h07A, 32'h0000_0002);
        check_output("last_write_wins", 9'h07A);

        // Mid-cycle reset clears everything without a clock edge.
        apply_stimulus(9'h020, 32'hA5A5_A5A5);
        check_output("wr_0x020", 9'h020);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        compare("async_clear_0x020", spo, 32'h0);
        a  = 9'h040;
        d  = 32'h5A5A_5A5A;
        we = 1'b1;
        @(posedge clk);
        #1;
        compare("write_in_reset_now", spo, 32'h0);
        we = 1'b0;
        release_reset();
        check_output("write_in_reset_0x040", 9'h040);
        check_output("after_reset_0x020", 9'h020);
        check_output("after_reset_0x005", 9'h005);

        // Randomized traffic over a small address pool so reads hit written words.
        for (int i = 0; i < 60; i++) begin
            addr_t ra;
            ra = addr_t'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 1) ? addr_t'(9'h1F0) : addr_t'(9'h000));
            if ($urandom_range(0, 1) == 1) apply_stimulus(ra, word_t'($urandom));
            ra = addr_t'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 1) ? addr_t'(9'h1F0) : addr_t'(9'h000));
            check_output("random_read", ra);
        end

`ifdef DIST_MEM_DPO_EN
        apply_stimulus(9'h030, 32'h0BAD_C0DE);
        @(negedge clk);
        a    = 9'h030;
        dpra = 9'h031;
        #1;
        compare("dpo_spo_0x030", spo, 32'h0BAD_C0DE);
        compare("dpo_0x031", dpo, model_read(9'h031));
        dpra = 9'h030;
        #1;
        compare("dpo_0x030", dpo, 32'h0BAD_C0DE);
        for (int i = 0; i < 20; i++) begin
            addr_t ra;
            ra   = addr_t'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 1) ? addr_t'(9'h1F0) : addr_t'(9'h000));
            @(negedge clk);
            dpra = ra;
            #1;
            compare("dpo_random", dpo, model_read(ra));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
